mshr_mem_responder: RTL and testbench
=====================================

# mshr_mem_responder

Memory-side responder for the cache miss path. It pops outstanding miss requests from the MSHR read port and queues them in order. Each queued request is serviced against a small backing line store after a fixed latency. The block then returns a one-cycle fill/ack pulse carrying the original address tag, which the MSHR uses as its delete request. It sits between the MSHR and the memory model and is the consumer and responder end of the MSHR request/fill interface.

## Interface
- addr_tag_bits, 20, width of the address tag
- data_bits, 90, width of the line/request data
- depth_bits, 2, request queue depth is 2**depth_bits
- mem_index_bits, 4, backing store has 2**mem_index_bits lines, indexed by tag[mem_index_bits-1:0]
- latency, 4, service cycles per request (>=1)

Ports:
- clk  in  1  clock; all state updates on posedge
- reset  in  1  asynchronous, active-high
- enable  in  1  global advance; low freezes all state
- req_valid  in  1  MSHR has an unread entry
- req_tag  in  addr_tag_bits  tag of the offered entry
- req_data  in  data_bits  data of the offered entry (write data for writes)
- req_rw  in  1  1 = write, 0 = read
- req_pop  out  1  request accepted this cycle; drives MSHR read_next
- resp_valid  out  1  one-cycle fill/ack pulse; drives MSHR del
- resp_tag  out  addr_tag_bits  tag being completed; drives MSHR del_addr_tag
- resp_data  out  data_bits  read: stored line; write: written data
- resp_rw  out  1  rw bit of completed request
- queue_count  out  depth_bits+1  occupied queue entries
- busy  out  1  FSM not IDLE

## Operation
- Queue: in-order FIFO of {tag, data, rw}, with wrapping read/write pointers (depth_bits wide) and a count (depth_bits+1 wide).
- Accept: req_pop = enable & req_valid & (queue_count < 2**depth_bits), combinational. The queue is written at the posedge ending a cycle with req_pop=1.
- Full is conservative: req_pop is low whenever count is 2**depth_bits, even during a RESP cycle.
- FSM states:
  - IDLE: count>0 -> BUSY, timer = latency-1.
  - BUSY: timer==0 -> RESP; else timer-1.
  - RESP: pop head. If entries remain after the pop (count-1+push > 0), go to BUSY with timer = latency-1; else go to IDLE.
- Service: head index = head tag[mem_index_bits-1:0].
  - Read: resp_data = mem[index], combinational during RESP.
  - Write: resp_data = head data, and mem[index] <= head data at the RESP edge.
- resp_valid = enable & (state==RESP). While resp_valid is 0, resp_tag, resp_data and resp_rw are 0.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Pointer wrap: pointers roll over from 2**depth_bits-1 to 0.
- enable=0: no push, no pop, no timer decrement, no memory write, resp_valid=0. Resumes exactly where it stopped.
- Reset (any time, including mid-BUSY or RESP): state IDLE, timer 0, pointers 0, count 0, all queue entries 0, all mem lines 0. In-flight requests are dropped and no response is emitted.

## Timing
- Reset values: req_pop 0, resp_valid 0, resp_tag 0, resp_data 0, resp_rw 0, queue_count 0, busy 0.
- A request accepted in cycle 0 into an empty idle block: IDLE in cycle 1, BUSY in cycles 2..latency+1, resp_valid in cycle latency+2.
- Back-to-back queued requests complete every latency+1 cycles (RESP goes straight to BUSY).
- queue_count reflects pushes and pops one cycle after the accepting or RESP cycle.
- resp_valid is high for exactly one enabled cycle per accepted request. Requests complete strictly in acceptance order.

## Test plan
- Defaults, reset, then a read of tag 0x00012 offered in cycle 0 -> req_pop=1 in cycle 0; resp_valid only in cycle 6 with resp_tag=0x00012, resp_data=0, resp_rw=0.
- Write tag 0x00013 with data 0x155 in cycle 0, then read tag 0x00023 in cycle 1 -> write resp in cycle 6 (data 0x155, rw=1); read resp in cycle 11 with resp_data=0x155 (same index 3).
- req_valid held high with 5 distinct tags -> pops in cycles 0-3; count=4; req_pop low in cycles 4-6; 5th accepted in cycle 7; responses in cycles 6, 11, 16, 21, 26 in order.
- enable low for 3 cycles starting at the RESP cycle of a single read -> resp_valid 0 during the stall; a single pulse on the first re-enabled cycle; count drops only then.
- Reset asserted in cycle 3 (BUSY) of a write to tag 0x00005 -> all outputs 0 immediately; no resp_valid through cycle 20; a later read of tag 0x00005 returns 0.

Source files
------------

// File: rtl/mshr_mem_responder.sv
// Memory-side responder for the MSHR miss path: queues popped requests in order,
// services each against a small line store after a fixed latency, returns a fill/ack.
module mshr_mem_responder #(
  parameter int addr_tag_bits  = 20,
  parameter int data_bits      = 90,
  parameter int depth_bits     = 2,
  parameter int mem_index_bits = 4,
  parameter int latency        = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     req_valid,
  input  logic [addr_tag_bits-1:0] req_tag,
  input  logic [data_bits-1:0]     req_data,
  input  logic                     req_rw,
  output logic                     req_pop,
  output logic                     resp_valid,
  output logic [addr_tag_bits-1:0] resp_tag,
  output logic [data_bits-1:0]     resp_data,
  output logic                     resp_rw,
  output logic [depth_bits:0]      queue_count,
  output logic                     busy
);

  localparam int depth = 1 << depth_bits;
  localparam int lines = 1 << mem_index_bits;
  localparam int tw = (latency > 1) ? $clog2(latency) : 1;
  localparam logic [tw-1:0] t_init = tw'(latency - 1);
  localparam logic [depth_bits:0] full_cnt = (depth_bits + 1)'(depth);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t state, state_nx;
  logic [tw-1:0] timer, timer_nx;

  logic [addr_tag_bits-1:0] q_tag  [depth];
  logic [data_bits-1:0]     q_data [depth];
  logic                     q_rw   [depth];
  logic [data_bits-1:0]     mem    [lines];

  logic [depth_bits-1:0] rd_ptr, wr_ptr;
  logic [depth_bits:0]   count;
  logic                  push, pop;

  logic [addr_tag_bits-1:0]  head_tag;
  logic [data_bits-1:0]      head_data;
  logic                      head_rw;
  logic [mem_index_bits-1:0] idx;

  assign head_tag  = q_tag[rd_ptr];
  assign head_data = q_data[rd_ptr];
  assign head_rw   = q_rw[rd_ptr];
  assign idx       = head_tag[mem_index_bits-1:0];

  // Full check ignores a same-cycle pop on purpose.
  assign push = enable & req_valid & (count != full_cnt);
  assign pop  = enable & (state == RESP);

  assign req_pop     = push;
  assign resp_valid  = pop;
  assign resp_tag    = pop ? head_tag : '0;
  assign resp_rw     = pop ? head_rw : 1'b0;
  assign resp_data   = !pop ? '0 : (head_rw ? head_data : mem[idx]);
  assign queue_count = count;
  assign busy        = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < depth; i++) begin
        q_tag[i]  <= '0;
        q_data[i] <= '0;
        q_rw[i]   <= 1'b0;
      end
      for (int i = 0; i < lines; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        q_tag[wr_ptr]  <= req_tag;
        q_data[wr_ptr] <= req_data;
        q_rw[wr_ptr]   <= req_rw;
        wr_ptr         <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        if (head_rw) mem[idx] <= head_data;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      timer <= '0;
    end else begin
      state <= state_nx;
      timer <= timer_nx;
    end
  end

  always_comb begin
    state_nx = state;
    timer_nx = timer;
    if (enable) begin
      unique case (state)
        IDLE: begin
          if (count != '0) begin
            state_nx = BUSY;
            timer_nx = t_init;
          end
        end
        BUSY: begin
          if (timer == '0) state_nx = RESP;
          else timer_nx = timer - 1'b1;
        end
        RESP: begin
          if (push || count > 1) begin
            state_nx = BUSY;
            timer_nx = t_init;
          end else begin
            state_nx = IDLE;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mshr_mem_responder.sv
// Directed bench for mshr_mem_responder: vector table for single requests,
// hand sequences for queue-full, enable stall and mid-service reset.
module tb_mshr_mem_responder;

  logic        clk = 1'b0;
  logic        reset, enable, req_valid, req_rw;
  logic [19:0] req_tag;
  logic [89:0] req_data;
  logic        req_pop, resp_valid, resp_rw, busy;
  logic [19:0] resp_tag;
  logic [89:0] resp_data;
  logic [2:0]  queue_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mshr_mem_responder dut (
    .clk(clk), .reset(reset), .enable(enable),
    .req_valid(req_valid), .req_tag(req_tag),
    .req_data(req_data), .req_rw(req_rw),
    .req_pop(req_pop), .resp_valid(resp_valid),
    .resp_tag(resp_tag), .resp_data(resp_data),
    .resp_rw(resp_rw), .queue_count(queue_count),
    .busy(busy)
  );

  typedef struct {
    logic        v;
    logic [19:0] tag;
    logic [89:0] data;
    logic        rw;
    logic        en;
    logic        pop;
    logic        rv;
    logic [19:0] rtag;
    logic [89:0] rdata;
    logic        rrw;
    logic [2:0]  cnt;
    logic        bsy;
  } vec_t;

  vec_t tbl[21];

  task automatic chk(input string name, input logic [89:0] act,
                     input logic [89:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic v, input logic [19:0] t,
                        input logic [89:0] d, input logic rw,
                        input logic en);
    req_valid = v;
    req_tag   = t;
    req_data  = d;
    req_rw    = rw;
    enable    = en;
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string n);
    chk({n, " pop"}, 90'(req_pop), 90'(0));
    chk({n, " rv"}, 90'(resp_valid), 90'(0));
    chk({n, " tag"}, 90'(resp_tag), 90'(0));
    chk({n, " data"}, resp_data, 90'(0));
    chk({n, " rw"}, 90'(resp_rw), 90'(0));
    chk({n, " cnt"}, 90'(queue_count), 90'(0));
    chk({n, " busy"}, 90'(busy), 90'(0));
  endtask

  task automatic do_reset();
    set_in(1'b0, '0, '0, 1'b0, 1'b1);
    reset = 1'b1;
    #2;
    chk_zero("reset");
    next_cyc();
    reset = 1'b0;
    next_cyc();
  endtask

  function automatic vec_t mk(input logic v, input logic [19:0] t,
                              input logic [89:0] d, input logic rw,
                              input logic pop, input logic rv,
                              input logic [19:0] rt,
                              input logic [89:0] rd, input logic rrw,
                              input logic [2:0] cnt, input logic bsy);
    vec_t x;
    x.v = v; x.tag = t; x.data = d; x.rw = rw; x.en = 1'b1;
    x.pop = pop; x.rv = rv; x.rtag = rt; x.rdata = rd;
    x.rrw = rrw; x.cnt = cnt; x.bsy = bsy;
    return x;
  endfunction

  logic [19:0] tags5 [5];

  initial begin
    reset = 1'b0;
    set_in(1'b0, '0, '0, 1'b0, 1'b1);
    #1;

    // single read (cycles 0..7), then write+read to index 3 (8..20)
    for (int i = 0; i < 21; i++)
      tbl[i] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 3'd1, 1);
    tbl[0]  = mk(1, 20'h00012, 0, 0, 1, 0, 0, 0, 0, 3'd0, 0);
    tbl[1]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 3'd1, 0);
    tbl[6]  = mk(0, 0, 0, 0, 0, 1, 20'h00012, 0, 0, 3'd1, 1);
    tbl[7]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 3'd0, 0);
    tbl[8]  = mk(1, 20'h00013, 90'h155, 1, 1, 0, 0, 0, 0, 3'd0, 0);
    tbl[9]  = mk(1, 20'h00023, 0, 0, 1, 0, 0, 0, 0, 3'd1, 0);
    for (int i = 10; i < 14; i++)
      tbl[i] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 3'd2, 1);
    tbl[14] = mk(0, 0, 0, 0, 0, 1, 20'h00013, 90'h155, 1, 3'd2, 1);
    tbl[19] = mk(0, 0, 0, 0, 0, 1, 20'h00023, 90'h155, 0, 3'd1, 1);
    tbl[20] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 3'd0, 0);

    do_reset();
    for (int i = 0; i < 21; i++) begin
      set_in(tbl[i].v, tbl[i].tag, tbl[i].data, tbl[i].rw, tbl[i].en);
      @(negedge clk);
      chk($sformatf("v%0d pop", i), 90'(req_pop), 90'(tbl[i].pop));
      chk($sformatf("v%0d rv", i), 90'(resp_valid), 90'(tbl[i].rv));
      chk($sformatf("v%0d tag", i), 90'(resp_tag), 90'(tbl[i].rtag));
      chk($sformatf("v%0d data", i), resp_data, tbl[i].rdata);
      chk($sformatf("v%0d rw", i), 90'(resp_rw), 90'(tbl[i].rrw));
      chk($sformatf("v%0d cnt", i), 90'(queue_count), 90'(tbl[i].cnt));
      chk($sformatf("v%0d busy", i), 90'(busy), 90'(tbl[i].bsy));
      next_cyc();
    end

    // five requests against a 4-deep queue; index 3 must read back 0
    tags5[0] = 20'h00100; tags5[1] = 20'h00103; tags5[2] = 20'h00A21;
    tags5[3] = 20'h0BEE7; tags5[4] = 20'h12345;
    do_reset();
    begin
      int nacc;
      logic ep, er;
      nacc = 0;
      for (int c = 0; c <= 30; c++) begin
        if (nacc < 5) set_in(1'b1, tags5[nacc], 90'(c), 1'b0, 1'b1);
        else set_in(1'b0, '0, '0, 1'b0, 1'b1);
        ep = (c <= 3) || (c == 7);
        er = (c >= 6) && (c <= 26) && ((c - 6) % 5 == 0);
        @(negedge clk);
        chk($sformatf("full c%0d pop", c), 90'(req_pop), 90'(ep));
        chk($sformatf("full c%0d rv", c), 90'(resp_valid), 90'(er));
        if (er) begin
          chk($sformatf("full c%0d tag", c), 90'(resp_tag),
              90'(tags5[(c - 6) / 5]));
          chk($sformatf("full c%0d data", c), resp_data, 90'(0));
        end else begin
          chk($sformatf("full c%0d idle tag", c), 90'(resp_tag), 90'(0));
        end
        if (c == 4) chk("full cnt4", 90'(queue_count), 90'(4));
        if (c == 27) chk("full cnt27", 90'(queue_count), 90'(0));
        if (ep) nacc++;
        next_cyc();
      end
    end

    // enable low for the RESP cycle and the two after it
    do_reset();
    for (int c = 0; c <= 12; c++) begin
      if (c == 0) set_in(1'b1, 20'h00007, '0, 1'b0, 1'b1);
      else if (c == 7) set_in(1'b1, 20'h00099, '0, 1'b0, 1'b0);
      else set_in(1'b0, '0, '0, 1'b0, !(c >= 6 && c <= 8));
      @(negedge clk);
      chk($sformatf("stall c%0d rv", c), 90'(resp_valid), 90'(c == 9));
      if (c == 7) chk("stall pop", 90'(req_pop), 90'(0));
      if (c == 8) chk("stall cnt8", 90'(queue_count), 90'(1));
      if (c == 9) chk("stall tag", 90'(resp_tag), 90'(20'h00007));
      if (c == 10) chk("stall cnt10", 90'(queue_count), 90'(0));
      next_cyc();
    end

    // reset during BUSY of a write; nothing may complete
    do_reset();
    for (int c = 0; c <= 3; c++) begin
      if (c == 0) set_in(1'b1, 20'h00005, 90'hABC, 1'b1, 1'b1);
      else set_in(1'b0, '0, '0, 1'b0, 1'b1);
      @(negedge clk);
      if (c == 3) begin
        chk("rst busy before", 90'(busy), 90'(1));
        reset = 1'b1;
        #1;
        chk_zero("midrst");
      end
      next_cyc();
    end
    reset = 1'b0;
    for (int c = 4; c <= 20; c++) begin
      @(negedge clk);
      chk($sformatf("rst c%0d rv", c), 90'(resp_valid), 90'(0));
      next_cyc();
    end
    for (int c = 0; c <= 7; c++) begin
      if (c == 0) set_in(1'b1, 20'h00005, '0, 1'b0, 1'b1);
      else set_in(1'b0, '0, '0, 1'b0, 1'b1);
      @(negedge clk);
      chk($sformatf("rd5 c%0d rv", c), 90'(resp_valid), 90'(c == 6));
      if (c == 6) begin
        chk("rd5 tag", 90'(resp_tag), 90'(20'h00005));
        chk("rd5 data", resp_data, 90'(0));
        chk("rd5 rw", 90'(resp_rw), 90'(0));
      end
      next_cyc();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
